bitty_fetch_unit: RTL and testbench
===================================

Name: bitty_fetch_unit

Overview:
Instruction fetch/issue stage that sits directly upstream of bitty_core. It keeps a program counter and reads 16-bit instructions from a synchronous instruction ROM (one-cycle read latency). It presents each instruction to the core with a one-cycle run pulse, waits for the core's done pulse, then advances. A watchdog flags a core that never returns done.

Parameters:
ADDR_W, 8, instruction memory address width; PC width.
PROG_LEN, 256, number of valid program words; must satisfy 1 <= PROG_LEN <= 2**ADDR_W.
TIMEOUT, 64, maximum cycles in EXEC waiting for done before error; must be >= 2.
HALT_OP, 16'hFFFF, instruction encoding that stops fetching; it is never issued to the core.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
start  input  1  level; sampled only in IDLE; begins execution at PC=0.
mem_en  output  1  ROM read enable.
mem_addr  output  ADDR_W  ROM read address; always equals pc.
mem_rdata  input  16  ROM data; valid the cycle after mem_en=1.
instruction  output  16  instruction to core; held stable from the run pulse until done.
run  output  1  single-cycle pulse to core.
done  input  1  single-cycle completion pulse from core.
pc  output  ADDR_W  current program counter.
halted  output  1  program finished, either by HALT_OP or by passing PROG_LEN-1.
error  output  1  watchdog expired; sticky until reset.

Behaviour:
- Reset, asynchronous on reset=0: state=IDLE, pc=0, instruction=16'h0000, run=0, mem_en=0, halted=0, error=0, watchdog=0.
- States: IDLE, FETCH, WAIT_MEM, ISSUE, EXEC, HALT, ERROR.
- IDLE: if start=1, go to FETCH; pc is already 0.
- FETCH: mem_en=1 for this cycle only; go to WAIT_MEM.
- WAIT_MEM: capture mem_rdata.
  - If it equals HALT_OP, go to HALT; instruction is not updated.
  - Otherwise, instruction <= mem_rdata and go to ISSUE.
- ISSUE: run=1 for exactly this cycle; clear watchdog; go to EXEC.
- EXEC: run=0; watchdog increments each cycle.
  - If done=1: if pc == PROG_LEN-1, go to HALT with pc unchanged. Otherwise pc <= pc+1 and go to FETCH.
  - Else if watchdog reaches TIMEOUT-1, go to ERROR.
  - If done=1 and the timeout condition fall in the same cycle, done wins.
- HALT: halted=1. Stay until reset; start is ignored.
- ERROR: error=1, halted=0, run=0. Stay until reset.
- Minimum issue-to-issue interval is 4 cycles (FETCH, WAIT_MEM, ISSUE, EXEC with immediate done).
- done in any state other than EXEC is ignored, including a done in the same cycle as the run pulse.
- start held high or re-asserted while not in IDLE has no effect.
- The pc increment never wraps: PROG_LEN-1 is always terminal. With PROG_LEN = 2**ADDR_W, the last address is 2**ADDR_W-1.
- Reset asserted mid-instruction returns to IDLE immediately, regardless of core state. The core shares the same reset.
- mem_addr is driven combinationally from pc. mem_en and run are registered outputs.

Decomposition:
- Shared package bitty_pkg:
  - state enum (IDLE..ERROR);
  - INSTR_W=16;
  - the default HALT_OP constant.
- One natural sub-module: bitty_watchdog, a loadable down/up counter with clear, enable, and expired output. It is reusable by later multi-cycle stages.
- The PC and FSM stay in the top module.

Test Plan:
- Straight-line program: ROM[0..2] = 16'h1234, 16'h5678, 16'hFFFF; start=1; core model returns done 3 cycles after run. Required: run pulses twice with instruction 16'h1234 then 16'h5678; halted=1 with pc=2; no third run.
- Length limit: PROG_LEN=4, no HALT_OP in ROM. Required: exactly 4 run pulses at pc=0..3; halted=1, pc stays 3, mem_en never asserted for address 4.
- Timeout: TIMEOUT=8, core never asserts done. Required: error=1 on the 8th EXEC cycle after the run pulse; run stays 0 thereafter; start ignored.
- Boundary races:
  - done asserted in the same cycle as watchdog expiry: required pc advances and error stays 0.
  - spurious done during FETCH: required no pc change.
- Reset mid-EXEC: pulse reset=0 for 1 cycle with pc=5. Required: pc=0, run=0, instruction=16'h0000, state IDLE; re-start refetches from address 0.
- Back-to-back throughput: done returned in the cycle after run. Required: run pulses every 4 cycles; mem_addr tracks pc in every cycle.

Source files
------------

// File: rtl/bitty_pkg.sv
// rtl/bitty_pkg.sv - shared types and constants for the bitty fetch stage
package bitty_pkg;

  localparam int INSTR_W = 16;

  // Fetching stops on this word; it never reaches the core.
  localparam logic [INSTR_W-1:0] DEFAULT_HALT_OP = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_MEM = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_EXEC     = 3'd4,
    ST_HALT     = 3'd5,
    ST_ERROR    = 3'd6
  } fetch_state_e;

endpackage

// File: rtl/bitty_watchdog.sv
// rtl/bitty_watchdog.sv - loadable up/down cycle counter with clear, enable and expiry flag
module bitty_watchdog #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             count_up,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Up mode expires at limit, down mode at zero; the count holds once expired.
  assign expired = count_up ? (count == limit) : (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && !expired) begin
      count <= count_up ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/bitty_fetch_unit.sv
// rtl/bitty_fetch_unit.sv - PC, ROM fetch and run/done handshake in front of bitty_core
module bitty_fetch_unit
  import bitty_pkg::*;
#(
  parameter int                 ADDR_W   = 8,
  parameter int                 PROG_LEN = 256,
  parameter int                 TIMEOUT  = 64,
  parameter logic [INSTR_W-1:0] HALT_OP  = DEFAULT_HALT_OP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               run,
  input  logic               done,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               error
);

  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_LEN - 1);
  localparam int                WD_W     = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT - 1);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] pc_next;
  logic              wd_expired;
  logic              is_halt_word;

  assign mem_addr     = pc;
  assign is_halt_word = (mem_rdata == HALT_OP);

  // Counts EXEC cycles; cleared while the run pulse is out so the first EXEC cycle sees zero.
  bitty_watchdog #(
    .WIDTH (WD_W)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .clear      (state == ST_ISSUE),
    .load       (1'b0),
    .load_value ('0),
    .enable     (state == ST_EXEC),
    .count_up   (1'b1),
    .limit      (WD_LIMIT),
    .expired    (wd_expired)
  );

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      ST_IDLE:     if (start) state_next = ST_FETCH;
      ST_FETCH:    state_next = ST_WAIT_MEM;
      ST_WAIT_MEM: state_next = is_halt_word ? ST_HALT : ST_ISSUE;
      ST_ISSUE:    state_next = ST_EXEC;
      ST_EXEC: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (done) begin
          if (pc == LAST_PC) begin
            state_next = ST_HALT;
          end else begin
            pc_next    = pc + ADDR_W'(1);
            state_next = ST_FETCH;
          end
        end else if (wd_expired) begin
          state_next = ST_ERROR;
        end
      end
      ST_HALT:     state_next = ST_HALT;
      ST_ERROR:    state_next = ST_ERROR;
      default:     state_next = ST_IDLE;
    endcase
  end

  // mem_en, run, halted and error are registered from the next state so each is a clean flop output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      instruction <= '0;
      mem_en      <= 1'b0;
      run         <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      mem_en <= (state_next == ST_FETCH);
      run    <= (state_next == ST_ISSUE);
      halted <= (state_next == ST_HALT);
      error  <= (state_next == ST_ERROR);
      if (state == ST_WAIT_MEM && !is_halt_word) begin
        instruction <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// tb/tb_bitty_fetch_unit.sv - scoreboard bench for bitty_fetch_unit with ROM and core models
module tb_bitty_fetch_unit;
  import bitty_pkg::*;

  localparam int ADDR_W   = 3;
  localparam int PROG_LEN = 8;
  localparam int TIMEOUT  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata = 16'h0000;
  logic [15:0]       instruction;
  logic              run;
  logic              done = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              error;

  logic [15:0]       rom [0:7];
  int                checks = 0;
  int                errors = 0;
  int                cycle = 0;
  int                mem_en_count = 0;
  int                done_delay = 3;
  bit                core_enable = 1'b1;
  bit                spurious = 1'b0;
  bit                track_addr = 1'b0;
  logic [ADDR_W-1:0] exp_pc_q [$];
  logic [15:0]       exp_instr_q [$];
  int                run_times [$];

  bitty_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .PROG_LEN (PROG_LEN),
    .TIMEOUT  (TIMEOUT),
    .HALT_OP  (16'hFFFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instruction (instruction),
    .run         (run),
    .done        (done),
    .pc          (pc),
    .halted      (halted),
    .error       (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= rom[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: done comes done_delay cycles after run; optional stray done in FETCH/ISSUE.
  initial begin
    int pending = 0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (!reset) begin
        pending = 0;
      end else begin
        if (pending > 0) begin
          pending--;
          if (pending == 0) done = 1'b1;
        end
        if (spurious && (mem_en || run)) done = 1'b1;
        if (run && core_enable) pending = done_delay;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (reset) begin
        if (mem_en) mem_en_count++;
        if (track_addr) check("mem_addr_tracks_pc", 32'(mem_addr), 32'(pc));
        if (run) begin
          run_times.push_back(cycle);
          if (exp_pc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_run: got run at pc %0h instr %0h expected no run", pc, instruction);
          end else begin
            check("run_pc", 32'(pc), 32'(exp_pc_q.pop_front()));
            check("run_instruction", 32'(instruction), 32'(exp_instr_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic apply_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] p, input logic [15:0] i);
    exp_pc_q.push_back(p);
    exp_instr_q.push_back(i);
  endtask

  task automatic fill_rom(input logic [15:0] base);
    for (int i = 0; i < 8; i++) rom[i] = base + 16'(i);
  endtask

  task automatic wait_end(input string name, input int budget);
    int n = 0;
    while (!(halted || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_terminated"}, 32'(halted || error), 32'd1);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int n;
    fill_rom(16'h0000);
    apply_reset();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_instruction", 32'(instruction), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_error", 32'(error), 32'd0);

    // Straight-line program ending on HALT_OP, with stray done pulses in FETCH and ISSUE.
    rom[0] = 16'h1234; rom[1] = 16'h5678; rom[2] = 16'hFFFF;
    done_delay = 3;
    spurious = 1'b1;
    push_exp(3'd0, 16'h1234);
    push_exp(3'd1, 16'h5678);
    pulse_start();
    wait_end("straight", 200);
    spurious = 1'b0;
    check("straight_halted", 32'(halted), 32'd1);
    check("straight_pc", 32'(pc), 32'd2);
    check("straight_error", 32'(error), 32'd0);
    check("straight_instr_kept", 32'(instruction), 32'h5678);
    check("straight_queue_empty", 32'(exp_pc_q.size()), 32'd0);

    // Length limit: every address valid, last PC (2**ADDR_W-1) is terminal.
    apply_reset();
    fill_rom(16'h0100);
    done_delay = 2;
    mem_en_count = 0;
    for (int i = 0; i < 8; i++) push_exp(3'(i), 16'h0100 + 16'(i));
    pulse_start();
    wait_end("length", 400);
    check("length_halted", 32'(halted), 32'd1);
    check("length_pc", 32'(pc), 32'd7);
    check("length_mem_en_count", 32'(mem_en_count), 32'd8);
    check("length_error", 32'(error), 32'd0);
    check("length_queue_empty", 32'(exp_pc_q.size()), 32'd0);

    // Watchdog timeout: core never answers, start stays high.
    apply_reset();
    fill_rom(16'h0000);
    rom[0] = 16'hABCD;
    core_enable = 1'b0;
    push_exp(3'd0, 16'hABCD);
    start = 1'b1;
    n = 0;
    while (!run && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("timeout_run_seen", 32'(run), 32'd1);
    repeat (8) @(negedge clk);
    check("timeout_error_before", 32'(error), 32'd0);
    @(negedge clk);
    check("timeout_error", 32'(error), 32'd1);
    check("timeout_halted", 32'(halted), 32'd0);
    check("timeout_run", 32'(run), 32'd0);
    repeat (10) @(negedge clk);
    check("timeout_error_sticky", 32'(error), 32'd1);
    check("timeout_pc", 32'(pc), 32'd0);
    start = 1'b0;
    core_enable = 1'b1;

    // done arrives on the very cycle the watchdog expires.
    apply_reset();
    rom[0] = 16'h1111; rom[1] = 16'hFFFF;
    done_delay = 8;
    push_exp(3'd0, 16'h1111);
    pulse_start();
    wait_end("race", 100);
    check("race_error", 32'(error), 32'd0);
    check("race_halted", 32'(halted), 32'd1);
    check("race_pc", 32'(pc), 32'd1);

    // Reset during EXEC at pc=5, then rerun from address 0.
    apply_reset();
    fill_rom(16'h0200);
    done_delay = 5;
    for (int i = 0; i < 6; i++) push_exp(3'(i), 16'h0200 + 16'(i));
    pulse_start();
    n = 0;
    while (!(run && pc == 3'd5) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midreset_reached_pc5", 32'(run && pc == 3'd5), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_pc", 32'(pc), 32'd0);
    check("midreset_run", 32'(run), 32'd0);
    check("midreset_instruction", 32'(instruction), 32'd0);
    check("midreset_mem_en", 32'(mem_en), 32'd0);
    check("midreset_state", 32'(dut.state), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    check("midreset_queue_empty", 32'(exp_pc_q.size()), 32'd0);
    for (int i = 0; i < 8; i++) push_exp(3'(i), 16'h0200 + 16'(i));
    pulse_start();
    wait_end("restart", 400);
    check("restart_halted", 32'(halted), 32'd1);
    check("restart_pc", 32'(pc), 32'd7);
    check("restart_queue_empty", 32'(exp_pc_q.size()), 32'd0);

    // Back-to-back: done the cycle after run gives a 4-cycle issue interval.
    apply_reset();
    fill_rom(16'hA000);
    rom[4] = 16'hFFFF;
    done_delay = 1;
    for (int i = 0; i < 4; i++) push_exp(3'(i), 16'hA000 + 16'(i));
    run_times.delete();
    track_addr = 1'b1;
    pulse_start();
    wait_end("b2b", 100);
    track_addr = 1'b0;
    check("b2b_run_count", 32'(run_times.size()), 32'd4);
    for (int i = 1; i < run_times.size(); i++)
      check("b2b_interval", 32'(run_times[i] - run_times[i-1]), 32'd4);
    check("b2b_halted", 32'(halted), 32'd1);
    check("b2b_pc", 32'(pc), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
